serial_sub_ctrl: RTL
====================

// Module: serial_sub_ctrl
// PURPOSE
//   Bit-serial N-bit subtractor. Sequences one fullSubtractor cell over WIDTH
//   cycles, LSB first, carrying the borrow in a flop between cycles. Trades
//   area for latency in the lab datapath. Uses a start/busy/done handshake.
//   The result is registered and held until the next operation completes.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 1
// PORTS
//   clk    in   1      rising-edge clock; the only clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  minuend; sampled on the accepted start cycle
//   b      in   WIDTH  subtrahend; sampled on the accepted start cycle
//   bin    in   1      initial borrow-in; sampled on the accepted start cycle
//   busy   out  1      high while in SHIFT or DONE
//   done   out  1      one-cycle pulse; diff/bout are new on this cycle
//   diff   out  WIDTH  registered result, a - b - bin (mod 2^WIDTH)
//   bout   out  1      registered final borrow-out (1 when a < b + bin)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; busy=0, done=0, diff=0, bout=0;
//     all internal registers cleared.
//   Internal state: sa, sb (WIDTH shift regs), brw (borrow flop),
//     acc (WIDTH shift reg), cnt ($clog2(WIDTH+1) bits).
//   FSM:
//     IDLE : start=1 -> load sa=a, sb=b, brw=bin, cnt=0; go to SHIFT.
//     SHIFT: fullSubtractor(A=sa[0], B=sb[0], BIn=brw) every cycle.
//            acc <= {Difference, acc[WIDTH-1:1]}; brw <= Bout.
//            sa, sb shift right by 1; cnt++.
//            When cnt==WIDTH-1: update diff with the final acc value
//            (including this cycle's bit) and bout with this cycle's Bout;
//            go to DONE.
//     DONE : done=1 for exactly this cycle; go to IDLE.
//   Latency: start accepted at edge 0 -> done high in cycle WIDTH+1.
//     Next start is accepted in cycle WIDTH+2 (throughput 1 op / WIDTH+2).
//   start while busy (SHIFT or DONE): ignored, no queuing. Input changes to
//     a/b/bin after acceptance have no effect.
//   diff/bout change only on entry to DONE. They stay stable through the
//     whole following operation.
//   WIDTH=1: SHIFT lasts one cycle; behaves as a registered full subtractor.
//   rst_n low mid-operation: abort immediately and return to the reset
//     values. No done pulse is issued for the aborted op.
//   Arithmetic: modular; diff == (a - b - bin) mod 2^WIDTH.
//     bout == (a < b + bin), unsigned.
// TESTING
//   1. WIDTH=8, a=8'h5A b=8'h3C bin=0 -> done in cycle 9, diff=8'h1E bout=0.
//   2. WIDTH=8, a=8'h00 b=8'h01 bin=0 -> diff=8'hFF bout=1;
//      a=8'h80 b=8'h80 bin=1 -> diff=8'hFF bout=1.
//   3. start pulsed during SHIFT with different a/b -> ignored; the first op's
//      result is unchanged; exactly one done pulse.
//   4. Back-to-back: start held high continuously -> ops accepted every 10
//      cycles; diff is stable between done pulses.
//   5. rst_n low at SHIFT cycle 4 -> busy=0, diff=0, no done; a new start
//      after release gives the correct result.
//   6. WIDTH=1: all 8 {a,b,bin} combos 000..111 -> {diff,bout} =
//      00,11,11,01,10,00,00,11.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor. A single full-subtractor cell is reused
// over WIDTH cycles, LSB first, with the borrow kept in a flop between bits.
// A start/busy/done handshake frames each operation. The result registers
// hold their value until the next operation completes.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fsDiff;
  logic             fsBout;
  logic [WIDTH:0]   accWide;
  logic [WIDTH-1:0] accNext;

  // Full-subtractor cell on the current LSBs, plus the accumulator value
  // with this cycle's difference bit shifted in at the top.
  always_comb begin
    fsDiff  = sa_q[0] ^ sb_q[0] ^ brw_q;
    fsBout  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    accWide = {fsDiff, acc_q};
    accNext = accWide[WIDTH:1];
  end

  // Next-state logic: load operands in IDLE, one bit per cycle in SHIFT,
  // publish the result on the last bit, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = accNext;
        brw_d = fsBout;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = accNext;
          bout_d  = fsBout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Handshake and result outputs come straight from registers.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
  end

endmodule
